// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the transmit queue and the transmitter.
//   BYTE_W            : data byte width
//   UART_LGFLEN_OK(l) : true when a queue depth exponent is in the legal range
`ifndef UART_PKG_SV
`define UART_PKG_SV

`define UART_LGFLEN_OK(l) (((l) >= 2) && ((l) <= 10))

package uart_pkg;
  localparam int unsigned BYTE_W = 8;
endpackage

`endif

// File: rtl/uart_txfifo_mem.sv
// Queue storage: one write port, one read port, 2^LGFLEN-1 bytes, no reset.
// The read is combinational from a registered address (the read pointer).
// The caller captures the data into its output register, so the array maps
// onto distributed RAM.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data
module uart_txfifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LGFLEN-1:0] i_waddr,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic [LGFLEN-1:0] i_raddr,
  output logic [BYTE_W-1:0] o_rdata
);
  localparam int unsigned DEPTH = (1 << LGFLEN) - 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/uart_txfifo.sv
// UART transmit queue. A circular memory plus an output register holding the
// head byte presented to the transmitter. Total capacity is 2^LGFLEN bytes.
//   i_clk, i_reset_n  : clock, synchronous active-low reset
//   i_wr, i_data      : bus-side enqueue strobe and byte
//   i_flush           : discard all queued bytes
//   i_clr_ovfl        : clear the sticky overflow flag
//   o_tx_wr, o_tx_data: head byte valid / value toward the transmitter
//   i_tx_busy         : transmitter busy; a transfer is o_tx_wr && !i_tx_busy
//   o_fill, o_full, o_half_empty, o_overflow : level and status flags
module uart_txfifo
  import uart_pkg::*;
#(
  parameter int unsigned LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_flush,
  input  logic              i_clr_ovfl,
  output logic              o_tx_wr,
  output logic [BYTE_W-1:0] o_tx_data,
  input  logic              i_tx_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_full,
  output logic              o_half_empty,
  output logic              o_overflow
);
  if (!`UART_LGFLEN_OK(LGFLEN)) begin : g_bad_lgflen
    $error("uart_txfifo: LGFLEN must be in 2..10");
  end

  localparam int unsigned       CAP       = 1 << LGFLEN;
  localparam logic [LGFLEN-1:0] PTR_LAST  = LGFLEN'(CAP - 2);
  localparam logic [LGFLEN:0]   FILL_CAP  = (LGFLEN+1)'(CAP);
  localparam logic [LGFLEN:0]   FILL_HALF = (LGFLEN+1)'(CAP / 2);

  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              tx_wr_q, tx_wr_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              full_q, full_d;
  logic              half_q, half_d;
  logic              ovfl_q, ovfl_d;

  logic              xfer, mem_empty, accept, drop, bypass, mem_rd, mem_we;
  logic [BYTE_W-1:0] mem_rdata;

  // Memory depth is not a power of two, so wrap by compare-and-clear.
  function automatic logic [LGFLEN-1:0] ptr_inc(input logic [LGFLEN-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  uart_txfifo_mem #(
    .LGFLEN (LGFLEN)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (mem_rdata)
  );

  always_comb begin
    xfer      = tx_wr_q && !i_tx_busy;
    // Output register empty implies memory empty, so memory holds fill - tx_wr.
    mem_empty = (fill_q == {{LGFLEN{1'b0}}, tx_wr_q});
    accept    = i_wr && !full_q && !i_flush;
    drop      = i_wr && full_q && !i_flush;
    bypass    = accept && mem_empty && (!tx_wr_q || xfer);
    mem_rd    = xfer && !mem_empty;
    mem_we    = accept && !bypass;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    tx_wr_d   = tx_wr_q;
    tx_data_d = tx_data_q;

    if (mem_we) wr_ptr_d = ptr_inc(wr_ptr_q);

    if (mem_rd) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      tx_data_d = mem_rdata;
      tx_wr_d   = 1'b1;
    end else if (bypass) begin
      tx_data_d = i_data;
      tx_wr_d   = 1'b1;
    end else if (xfer) begin
      tx_wr_d   = 1'b0;
    end

    case ({accept, xfer})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      tx_wr_d  = 1'b0;
    end

    full_d = (fill_d == FILL_CAP);
    half_d = (fill_d <= FILL_HALF);

    if (drop)            ovfl_d = 1'b1;
    else if (i_clr_ovfl) ovfl_d = 1'b0;
    else                 ovfl_d = ovfl_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      full_q    <= 1'b0;
      half_q    <= 1'b1;
      ovfl_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      full_q    <= full_d;
      half_q    <= half_d;
      ovfl_q    <= ovfl_d;
    end
  end

  assign o_tx_wr      = tx_wr_q;
  assign o_tx_data    = tx_data_q;
  assign o_fill       = fill_q;
  assign o_full       = full_q;
  assign o_half_empty = half_q;
  assign o_overflow   = ovfl_q;
endmodule

// File: tb/tb_uart_txfifo.sv
module tb_uart_txfifo;
  localparam int unsigned LGFLEN = 4;

  logic            i_clk = 1'b0;
  logic            i_reset_n, i_wr, i_flush, i_clr_ovfl, i_tx_busy;
  logic [7:0]      i_data, o_tx_data;
  logic            o_tx_wr, o_full, o_half_empty, o_overflow;
  logic [LGFLEN:0] o_fill;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 i_clk = ~i_clk;

  uart_txfifo #(
    .LGFLEN (LGFLEN)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_wr         (i_wr),
    .i_data       (i_data),
    .i_flush      (i_flush),
    .i_clr_ovfl   (i_clr_ovfl),
    .o_tx_wr      (o_tx_wr),
    .o_tx_data    (o_tx_data),
    .i_tx_busy    (i_tx_busy),
    .o_fill       (o_fill),
    .o_full       (o_full),
    .o_half_empty (o_half_empty),
    .o_overflow   (o_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic exp_wr, input logic [7:0] exp_data,
                             input int unsigned exp_fill, input logic exp_ovfl, input bit chk_data);
    check({tag, ".tx_wr"}, 32'(o_tx_wr), 32'(exp_wr));
    check({tag, ".fill"}, 32'(o_fill), 32'(exp_fill));
    check({tag, ".full"}, 32'(o_full), 32'(exp_fill == 16));
    check({tag, ".half"}, 32'(o_half_empty), 32'(exp_fill <= 8));
    check({tag, ".ovfl"}, 32'(o_overflow), 32'(exp_ovfl));
    if (chk_data) check({tag, ".data"}, 32'(o_tx_data), 32'(exp_data));
  endtask

  task automatic write(input logic [7:0] d);
    i_wr = 1'b1; i_data = d;
    step();
    i_wr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic       m_ovfl;
    logic       r_wr, r_busy, r_flush, r_clr, m_full, m_xfer;
    logic [7:0] r_data;

    i_reset_n = 1'b0; i_wr = 1'b0; i_data = '0; i_flush = 1'b0;
    i_clr_ovfl = 1'b0; i_tx_busy = 1'b0;
    #1;
    step(); step();

    // 1: reset values, single byte through
    check_state("reset", 1'b0, 8'h00, 0, 1'b0, 1'b1);
    i_reset_n = 1'b1;
    step();
    write(8'hA5);
    check_state("t1.loaded", 1'b1, 8'hA5, 1, 1'b0, 1'b1);
    step();
    check_state("t1.drained", 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // 2: fill to capacity, overflow, clear, set-beats-clear
    i_tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'(i));
    check_state("t2.full", 1'b1, 8'h00, 16, 1'b0, 1'b1);
    write(8'hEE);
    check_state("t2.ovfl", 1'b1, 8'h00, 16, 1'b1, 1'b1);
    i_clr_ovfl = 1'b1;
    step();
    check_state("t2.clr", 1'b1, 8'h00, 16, 1'b0, 1'b0);
    i_wr = 1'b1; i_data = 8'hEF;
    step();
    i_wr = 1'b0; i_clr_ovfl = 1'b0;
    check_state("t2.setwins", 1'b1, 8'h00, 16, 1'b1, 1'b1);

    // 3: drain with a transmitter busy for 3 cycles after each accept
    for (int k = 0; k < 16; k++) begin
      i_tx_busy = 1'b0;
      check_state($sformatf("t3.head%0d", k), 1'b1, 8'(k), 16 - k, 1'b1, 1'b1);
      step();
      i_tx_busy = 1'b1;
      check_state($sformatf("t3.after%0d", k), k != 15, 8'(k + 1), 15 - k, 1'b1, k != 15);
      step(); step(); step();
    end
    i_tx_busy = 1'b0;

    // 4: simultaneous write and transfer
    i_tx_busy = 1'b1;
    write(8'h11);
    i_tx_busy = 1'b0;
    write(8'h3C);
    check_state("t4.fill1", 1'b1, 8'h3C, 1, 1'b1, 1'b1);
    step();
    check_state("t4.empty", 1'b0, 8'h00, 0, 1'b1, 1'b0);
    i_tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) write(8'h20 + 8'(i));
    check_state("t4.fill5", 1'b1, 8'h20, 5, 1'b1, 1'b1);
    i_tx_busy = 1'b0;
    write(8'h25);
    check_state("t4.simul5", 1'b1, 8'h21, 5, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("t4.order%0d", i), 32'(o_tx_data), 32'h20 + 32'(i));
      step();
    end
    check_state("t4.drained", 1'b0, 8'h00, 0, 1'b1, 1'b0);

    // 5: flush with a coincident write
    i_tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) write(8'h30 + 8'(i));
    check_state("t5.fill10", 1'b1, 8'h30, 10, 1'b1, 1'b1);
    i_flush = 1'b1;
    write(8'h77);
    i_flush = 1'b0;
    check_state("t5.flushed", 1'b0, 8'h00, 0, 1'b1, 1'b0);
    write(8'h5A);
    check_state("t5.after", 1'b1, 8'h5A, 1, 1'b1, 1'b1);
    i_tx_busy = 1'b0;
    step();

    // 6: reset mid-stream, then random traffic against a queue model
    i_tx_busy = 1'b1;
    for (int i = 0; i < 7; i++) write(8'h40 + 8'(i));
    check_state("t6.fill7", 1'b1, 8'h40, 7, 1'b1, 1'b1);
    i_reset_n = 1'b0; i_wr = 1'b1; i_data = 8'h99; i_flush = 1'b1; i_tx_busy = 1'b0;
    step();
    i_wr = 1'b0; i_flush = 1'b0;
    check_state("t6.reset", 1'b0, 8'h00, 0, 1'b0, 1'b1);
    i_reset_n = 1'b1;
    step();

    q.delete();
    m_ovfl = 1'b0;
    for (int c = 0; c < 800; c++) begin
      check_state($sformatf("rnd%0d", c), q.size() != 0, (q.size() != 0) ? q[0] : 8'h00,
                  q.size(), m_ovfl, q.size() != 0);
      r_wr    = ($urandom_range(0, 99) < 55);
      r_busy  = ($urandom_range(0, 99) < 50);
      r_flush = ($urandom_range(0, 39) == 0);
      r_clr   = ($urandom_range(0, 15) == 0);
      r_data  = 8'($urandom);
      i_wr = r_wr; i_data = r_data; i_tx_busy = r_busy; i_flush = r_flush; i_clr_ovfl = r_clr;

      m_full = (q.size() == 16);
      m_xfer = (q.size() != 0) && !r_busy;
      if (r_flush) begin
        q.delete();
        if (r_clr) m_ovfl = 1'b0;
      end else begin
        if (m_xfer) void'(q.pop_front());
        if (r_wr && !m_full) q.push_back(r_data);
        if (r_wr && m_full) m_ovfl = 1'b1;
        else if (r_clr) m_ovfl = 1'b0;
      end
      step();
    end
    i_wr = 1'b0; i_flush = 1'b0; i_clr_ovfl = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_txfifo.md
# uart_txfifo

Transmit queue that sits directly upstream of the UART transmitter. It buffers bytes written by the bus-side register interface and presents them one at a time to the transmitter's `i_wr`/`i_data`/`o_busy` handshake. It reports fill level, full, half-empty and a sticky overflow flag so software can refill it by interrupt or by polling.

## Interface
- `LGFLEN`, default 4: log2 of capacity. Capacity is 2^LGFLEN bytes, counting the output register. Legal range is 2..10.
- `i_clk`  in  1: single clock for the block.
- `i_reset_n`  in  1: synchronous, active-low reset.
- `i_wr`  in  1: write strobe from the bus side, one byte per asserted cycle.
- `i_data`  in  8: byte to enqueue.
- `i_flush`  in  1: synchronous clear of all queued bytes.
- `i_clr_ovfl`  in  1: clears `o_overflow`.
- `o_tx_wr`  out  1: byte valid toward the transmitter (drives its `i_wr`).
- `o_tx_data`  out  8: head byte toward the transmitter (drives its `i_data`).
- `i_tx_busy`  in  1: transmitter busy (its `o_busy`).
- `o_fill`  out  LGFLEN+1: number of bytes held.
- `o_full`  out  1: `o_fill` == 2^LGFLEN.
- `o_half_empty`  out  1: `o_fill` <= 2^(LGFLEN-1). Level interrupt.
- `o_overflow`  out  1: sticky; a write was dropped.

## Operation
- **Storage:** a circular memory of 2^LGFLEN-1 entries plus one output register holding the head byte.
  - Write and read pointers are LGFLEN bits and wrap modulo 2^LGFLEN-1.
  - Pointer wrap must be explicit compare-and-clear, not natural overflow.
- **Transfer:** occurs on a cycle with `o_tx_wr` && !`i_tx_busy`.
  - On a transfer the output register reloads from memory if memory is non-empty. Otherwise `o_tx_wr` falls at the next edge.
  - `o_tx_data` is stable whenever `o_tx_wr` is high and no transfer has occurred.
- **Bypass:** if memory is empty and the output register is empty or transferring this cycle, a write loads the output register directly.
- **Write acceptance:**
  - A write is accepted iff `o_full` is low, using the registered value.
  - A write while `o_full` is high is dropped and sets `o_overflow`, even if a transfer happens in the same cycle.
- **Simultaneous write and transfer:** `o_fill` is unchanged. Order is preserved: the memory head moves to the output register and the new byte goes to the memory tail. Bypass applies only when memory is empty.
- **Flush:**
  - `i_flush` zeroes both pointers, `o_fill` and `o_tx_wr` at the next edge. It does not touch `o_overflow`.
  - A transfer occurring in the flush cycle still counts as taken by the transmitter.
  - A write in the flush cycle is discarded without setting overflow.
- **Overflow clear:** if `i_clr_ovfl` and a dropped write coincide, the set wins.
- **Reset:** while `i_reset_n` is low at an edge, the outputs go to:
  - `o_tx_wr`=0, `o_tx_data`=8'h00, `o_fill`=0, `o_full`=0, `o_half_empty`=1, `o_overflow`=0, pointers = 0.
  - Reset overrides flush, write and transfer.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **Write latency:** write to an empty queue at edge k gives `o_tx_wr`=1 and valid `o_tx_data` after edge k.
- **Fill update:** `o_fill`, `o_full` and `o_half_empty` update at the edge that accepts a write or completes a transfer. All three are consistent with each other in every cycle.
- **Back-to-back:** the transmitter raises busy the cycle after it accepts, so the next transfer happens at the earliest once busy drops. The queue itself must sustain one transfer per cycle if `i_tx_busy` is held low.
- **Memory:** reads are synchronous-style, with the address registered and data landing in the output register. This makes the memory inferable as distributed RAM.

## Structure
- Shared package/header `uart_pkg`: the `LGFLEN` range check macro and the byte width constant (8). The transmitter uses the same header.
- One sub-module, `uart_txfifo_mem`: a single-write-port, single-read-port memory, 8 bits × (2^LGFLEN-1) entries, with no reset on contents.
- Pointer, fill, bypass and flag logic live in `uart_txfifo`.

## Test plan
All scenarios use LGFLEN=4, so capacity is 16.
1. Reset, then write 8'hA5 with `i_tx_busy`=0 → one cycle later `o_tx_wr`=1 and `o_tx_data`=8'hA5, then transfer, then `o_fill` returns to 0.
2. Hold `i_tx_busy`=1 and write 16 bytes 0x00..0x0F → `o_full`=1, `o_fill`=16, `o_half_empty`=0. A 17th write sets `o_overflow`, and `o_fill` stays 16.
3. Release busy and model the transmitter pulsing busy for 3 cycles after each accept → bytes emerge 0x00..0x0F in order. `o_half_empty` rises exactly when `o_fill` reaches 8.
4. With the queue at fill 1 and the transfer cycle, write 8'h3C in the same cycle → `o_fill` stays 1 and the next head is 8'h3C. With fill 5, simultaneous write and transfer → order preserved, fill stays 5.
5. At fill 10, assert `i_flush` together with a write → next cycle `o_fill`=0, `o_tx_wr`=0, `o_overflow` unchanged. The following write appears after 1 cycle.
6. Assert reset mid-stream at fill 7 with `o_overflow`=1 → all outputs take their reset values at the next edge. Random write/busy/flush traffic checked against a reference queue model shows no loss, duplication or reordering.
